// File: rtl/stella_sprite_engine.sv
// -----------------------------------------------------------------------------
// stella_sprite_engine
//
// Per-frame game state for a simple "dodge the falling blocks" game and the
// pixel colour for the current scan position.
//
// State advances once per frame, on the first clock at which the scan counters
// reach the last visible pixel. If the scan counters hold that pixel for
// several clocks, the state still advances only once.
//
// Ports:
//   clk      in   pixel clock
//   rst_n    in   asynchronous active-low reset
//   x        in   scan column (10 bits)
//   y        in   scan row (9 bits)
//   movel    in   move-left button, level
//   mover    in   move-right button, level
//   color    out  registered {R,G,B} 4 bits each, one clock after x/y
//   collide  out  sticky game-over flag
//   score    out  obstacles that fell off the bottom, saturating
// -----------------------------------------------------------------------------
module stella_sprite_engine #(
    parameter int          H_RES     = 640,
    parameter int          V_RES     = 480,
    parameter int          N_OBS     = 4,
    parameter int          SHIP_W    = 32,
    parameter int          SHIP_H    = 32,
    parameter int          OBS_W     = 32,
    parameter int          OBS_H     = 32,
    parameter int          SHIP_STEP = 4,
    parameter int          OBS_SPEED = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  x,
    input  logic [8:0]  y,
    input  logic        movel,
    input  logic        mover,
    output logic [11:0] color,
    output logic        collide,
    output logic [15:0] score
);

    // All position arithmetic is carried at 11 bits so sums such as
    // ship_x + SHIP_W never wrap before they are compared.
    localparam logic [10:0] H_RES_W     = 11'(H_RES);
    localparam logic [10:0] V_RES_W     = 11'(V_RES);
    localparam logic [10:0] SHIP_W_W    = 11'(SHIP_W);
    localparam logic [10:0] SHIP_H_W    = 11'(SHIP_H);
    localparam logic [10:0] OBS_W_W     = 11'(OBS_W);
    localparam logic [10:0] OBS_H_W     = 11'(OBS_H);
    localparam logic [10:0] SHIP_STEP_W = 11'(SHIP_STEP);
    localparam logic [10:0] OBS_SPEED_W = 11'(OBS_SPEED);
    localparam logic [10:0] SHIP_Y      = 11'(V_RES - SHIP_H - 8);
    localparam logic [10:0] SHIP_X_RST  = 11'((H_RES - SHIP_W) / 2);
    localparam logic [10:0] SHIP_X_MAX  = 11'(H_RES - SHIP_W);
    localparam logic [10:0] OBS_X_MAX   = 11'(H_RES - OBS_W);
    localparam logic [15:0] LFSR_MASK   = 16'hB400;

    localparam logic [11:0] COL_BLACK = 12'h000;
    localparam logic [11:0] COL_SHIP  = 12'h0F0;
    localparam logic [11:0] COL_HIT   = 12'hF00;
    localparam logic [11:0] COL_OBS   = 12'hF80;

    logic [10:0] x_w;
    logic [10:0] y_w;
    logic        at_last;
    logic        tick;
    logic        last_q;

    logic [10:0] ship_x_q, ship_x_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [N_OBS-1:0] act_q, act_d;
    logic [9:0]  ox_q [N_OBS];
    logic [9:0]  ox_d [N_OBS];
    logic [9:0]  oy_q [N_OBS];
    logic [9:0]  oy_d [N_OBS];
    logic        collide_q, collide_d;
    logic [15:0] score_q, score_d;
    logic [11:0] color_q, color_d;

    logic [N_OBS-1:0] hit;
    logic [N_OBS-1:0] obs_pix;
    logic        ship_pix;
    logic        overlap;
    logic        spawn_done;
    logic [10:0] oy_next;
    logic [10:0] spawn_x;
    logic [3:0]  retire_cnt;
    logic [16:0] score_sum;

    assign x_w = {1'b0, x};
    assign y_w = {2'b0, y};

    assign at_last = (x_w == H_RES_W - 11'd1) && (y_w == V_RES_W - 11'd1);
    assign tick    = at_last && !last_q;

    assign color   = color_q;
    assign collide = collide_q;
    assign score   = score_q;

    // Per-slot overlap with the ship and with the current scan pixel.
    always_comb begin
        hit     = '0;
        obs_pix = '0;
        for (int i = 0; i < N_OBS; i++) begin
            hit[i] = act_q[i]
                  && ({1'b0, ox_q[i]} < ship_x_q + SHIP_W_W)
                  && (ship_x_q < {1'b0, ox_q[i]} + OBS_W_W)
                  && ({1'b0, oy_q[i]} < SHIP_Y + SHIP_H_W)
                  && (SHIP_Y < {1'b0, oy_q[i]} + OBS_H_W);
            obs_pix[i] = act_q[i]
                  && (x_w >= {1'b0, ox_q[i]})
                  && (x_w <  {1'b0, ox_q[i]} + OBS_W_W)
                  && (y_w >= {1'b0, oy_q[i]})
                  && (y_w <  {1'b0, oy_q[i]} + OBS_H_W);
        end
    end

    assign overlap  = |hit;
    assign ship_pix = (x_w >= ship_x_q) && (x_w < ship_x_q + SHIP_W_W)
                   && (y_w >= SHIP_Y)   && (y_w < SHIP_Y + SHIP_H_W);

    always_comb begin
        if (x_w >= H_RES_W || y_w >= V_RES_W) begin
            color_d = COL_BLACK;
        end else if (ship_pix) begin
            color_d = collide_q ? COL_HIT : COL_SHIP;
        end else if (|obs_pix) begin
            color_d = COL_OBS;
        end else begin
            color_d = COL_BLACK;
        end
    end

    // Frame update. Spawn eligibility looks at act_q, so a slot that retires
    // on this tick cannot be refilled until the next one.
    always_comb begin
        ship_x_d   = ship_x_q;
        lfsr_d     = lfsr_q;
        act_d      = act_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        collide_d  = collide_q;
        score_d    = score_q;
        oy_next    = '0;
        spawn_done = 1'b0;
        retire_cnt = '0;
        spawn_x    = {2'b0, lfsr_q[15:7]};
        score_sum  = '0;

        if (tick) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

            if (collide_q) begin
                if (movel && mover) begin
                    collide_d = 1'b0;
                    score_d   = '0;
                    ship_x_d  = SHIP_X_RST;
                    act_d     = '0;
                    for (int i = 0; i < N_OBS; i++) begin
                        ox_d[i] = '0;
                        oy_d[i] = '0;
                    end
                end
            end else begin
                if (movel && !mover) begin
                    ship_x_d = (ship_x_q > SHIP_STEP_W) ? ship_x_q - SHIP_STEP_W : 11'd0;
                end else if (mover && !movel) begin
                    ship_x_d = (ship_x_q + SHIP_STEP_W > SHIP_X_MAX) ? SHIP_X_MAX
                                                                     : ship_x_q + SHIP_STEP_W;
                end

                for (int i = 0; i < N_OBS; i++) begin
                    if (act_q[i]) begin
                        oy_next = {1'b0, oy_q[i]} + OBS_SPEED_W;
                        if (oy_next >= V_RES_W) begin
                            act_d[i]   = 1'b0;
                            retire_cnt = retire_cnt + 4'd1;
                        end else begin
                            oy_d[i] = oy_next[9:0];
                        end
                    end
                end

                if (lfsr_q[2:0] == 3'd0) begin
                    for (int i = 0; i < N_OBS; i++) begin
                        if (!spawn_done && !act_q[i]) begin
                            spawn_done = 1'b1;
                            act_d[i]   = 1'b1;
                            ox_d[i]    = (spawn_x > OBS_X_MAX) ? OBS_X_MAX[9:0] : spawn_x[9:0];
                            oy_d[i]    = '0;
                        end
                    end
                end

                score_sum = {1'b0, score_q} + {13'd0, retire_cnt};
                score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];

                if (overlap) begin
                    collide_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= 1'b0;
            ship_x_q  <= SHIP_X_RST;
            lfsr_q    <= LFSR_SEED;
            act_q     <= '0;
            collide_q <= 1'b0;
            score_q   <= '0;
            color_q   <= COL_BLACK;
            for (int i = 0; i < N_OBS; i++) begin
                ox_q[i] <= '0;
                oy_q[i] <= '0;
            end
        end else begin
            last_q    <= at_last;
            ship_x_q  <= ship_x_d;
            lfsr_q    <= lfsr_d;
            act_q     <= act_d;
            collide_q <= collide_d;
            score_q   <= score_d;
            color_q   <= color_d;
            for (int i = 0; i < N_OBS; i++) begin
                ox_q[i] <= ox_d[i];
                oy_q[i] <= oy_d[i];
            end
        end
    end

endmodule

// File: tb/tb_stella_sprite_engine.sv
module tb_stella_sprite_engine;

    localparam int H_RES     = 640;
    localparam int V_RES     = 480;
    localparam int N_OBS     = 4;
    localparam int SHIP_W    = 32;
    localparam int SHIP_H    = 32;
    localparam int OBS_W     = 32;
    localparam int OBS_H     = 32;
    localparam int SHIP_STEP = 4;
    localparam int OBS_SPEED = 2;
    localparam int SHIP_Y    = V_RES - SHIP_H - 8;
    localparam int SHIP_X0   = (H_RES - SHIP_W) / 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [9:0]  x     = '0;
    logic [8:0]  y     = '0;
    logic        movel = 1'b0;
    logic        mover = 1'b0;
    logic [11:0] color;
    logic        collide;
    logic [15:0] score;

    int checks = 0;
    int errors = 0;

    stella_sprite_engine #(
        .H_RES(H_RES), .V_RES(V_RES), .N_OBS(N_OBS),
        .SHIP_W(SHIP_W), .SHIP_H(SHIP_H), .OBS_W(OBS_W), .OBS_H(OBS_H),
        .SHIP_STEP(SHIP_STEP), .OBS_SPEED(OBS_SPEED), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .movel(movel), .mover(mover),
        .color(color), .collide(collide), .score(score)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_ship_x;
    bit          m_collide;
    int          m_score;
    logic [15:0] m_lfsr;
    bit          m_act [N_OBS];
    int          m_ox  [N_OBS];
    int          m_oy  [N_OBS];

    function automatic void model_reset();
        m_ship_x  = SHIP_X0;
        m_collide = 0;
        m_score   = 0;
        m_lfsr    = 16'hACE1;
        for (int i = 0; i < N_OBS; i++) begin
            m_act[i] = 0; m_ox[i] = 0; m_oy[i] = 0;
        end
    endfunction

    function automatic bit boxes_overlap(int ax, int ay, int aw, int ah, int bx, int by, int bw, int bh);
        return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
    endfunction

    function automatic void model_tick(bit ml, bit mr);
        int  retired;
        int  free_slot;
        bit  hit;
        int  rnd;
        retired   = 0;
        free_slot = -1;
        hit       = 0;
        if (m_collide) begin
            if (ml && mr) model_reset_keep_lfsr();
        end else begin
            for (int i = 0; i < N_OBS; i++) begin
                if (m_act[i] && boxes_overlap(m_ox[i], m_oy[i], OBS_W, OBS_H,
                                              m_ship_x, SHIP_Y, SHIP_W, SHIP_H))
                    hit = 1;
                if (!m_act[i] && free_slot < 0) free_slot = i;
            end
            if (ml && !mr) m_ship_x = (m_ship_x - SHIP_STEP < 0) ? 0 : m_ship_x - SHIP_STEP;
            if (mr && !ml) m_ship_x = (m_ship_x + SHIP_STEP > H_RES - SHIP_W) ? H_RES - SHIP_W
                                                                              : m_ship_x + SHIP_STEP;
            for (int i = 0; i < N_OBS; i++) begin
                if (m_act[i]) begin
                    m_oy[i] += OBS_SPEED;
                    if (m_oy[i] >= V_RES) begin
                        m_act[i] = 0;
                        retired++;
                    end
                end
            end
            if ((m_lfsr % 8) == 0 && free_slot >= 0) begin
                rnd = int'(m_lfsr) / 128;
                m_act[free_slot] = 1;
                m_ox[free_slot]  = (rnd > H_RES - OBS_W) ? H_RES - OBS_W : rnd;
                m_oy[free_slot]  = 0;
            end
            m_score = (m_score + retired > 65535) ? 65535 : m_score + retired;
            if (hit) m_collide = 1;
        end
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    endfunction

    function automatic void model_reset_keep_lfsr();
        logic [15:0] keep;
        keep = m_lfsr;
        model_reset();
        m_lfsr = keep;
    endfunction

    function automatic int model_color(int px, int py);
        if (px >= H_RES || py >= V_RES) return 'h000;
        if (px >= m_ship_x && px < m_ship_x + SHIP_W && py >= SHIP_Y && py < SHIP_Y + SHIP_H)
            return m_collide ? 'hF00 : 'h0F0;
        for (int i = 0; i < N_OBS; i++)
            if (m_act[i] && px >= m_ox[i] && px < m_ox[i] + OBS_W && py >= m_oy[i] && py < m_oy[i] + OBS_H)
                return 'hF80;
        return 'h000;
    endfunction

    // ---------------- check helpers ----------------
    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic probe(input int px, input int py, input string nm);
        x = px[9:0];
        y = py[8:0];
        @(posedge clk); #1;
        check($sformatf("%s(%0d,%0d)", nm, px, py), {20'd0, color}, model_color(px, py));
    endtask

    task automatic frame(input bit ml, input bit mr);
        int exp_tick_col;
        movel = ml; mover = mr;
        x = 10'd0; y = 9'd0;
        @(posedge clk); #1;
        exp_tick_col = model_color(H_RES - 1, V_RES - 1);
        x = 10'(H_RES - 1); y = 9'(V_RES - 1);
        @(posedge clk); #1;
        model_tick(ml, mr);
        check("tick_color", {20'd0, color}, exp_tick_col);
        check("collide", {31'd0, collide}, m_collide);
        check("score", {16'd0, score}, m_score);
    endtask

    task automatic ship_probes();
        if (m_ship_x > 0) probe(m_ship_x - 1, SHIP_Y, "ship_left_out");
        probe(m_ship_x, SHIP_Y, "ship_left_in");
        probe(m_ship_x + SHIP_W - 1, SHIP_Y + SHIP_H - 1, "ship_right_in");
        probe(m_ship_x + SHIP_W, SHIP_Y + SHIP_H - 1, "ship_right_out");
    endtask

    task automatic obs_probes();
        for (int i = 0; i < N_OBS; i++) begin
            if (m_act[i]) begin
                probe(m_ox[i], m_oy[i], "obs_tl");
                probe(m_ox[i] + OBS_W - 1, m_oy[i] + OBS_H - 1, "obs_br");
                probe(m_ox[i] + OBS_W, m_oy[i], "obs_right_out");
                break;
            end
        end
    endtask

    typedef struct {
        int          px;
        int          py;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int  tgt, best, px, py, r;
        bit  ml, mr;

        vecs[0]  = '{304, 440, 12'h0F0};
        vecs[1]  = '{303, 440, 12'h000};
        vecs[2]  = '{335, 471, 12'h0F0};
        vecs[3]  = '{336, 471, 12'h000};
        vecs[4]  = '{320, 439, 12'h000};
        vecs[5]  = '{320, 472, 12'h000};
        vecs[6]  = '{320, 456, 12'h0F0};
        vecs[7]  = '{640, 456, 12'h000};
        vecs[8]  = '{1000, 100, 12'h000};
        vecs[9]  = '{0, 0, 12'h000};
        vecs[10] = '{335, 440, 12'h0F0};
        vecs[11] = '{304, 471, 12'h0F0};

        // asynchronous reset, observed before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check("rst_color", {20'd0, color}, 0);
        check("rst_collide", {31'd0, collide}, 0);
        check("rst_score", {16'd0, score}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();

        // one-cycle colour latency
        x = 10'd320; y = 9'd450;
        #2;
        check("latency_before_edge", {20'd0, color}, 0);
        @(posedge clk); #1;
        check("latency_after_edge", {20'd0, color}, 12'h0F0);

        for (int i = 0; i < 12; i++) begin
            x = vecs[i].px[9:0];
            y = vecs[i].py[8:0];
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), {20'd0, color}, {20'd0, vecs[i].exp});
        end

        // last pixel held for 10 clocks: one step only
        mover = 1'b1; x = 10'd0; y = 9'd0;
        @(posedge clk); #1;
        x = 10'(H_RES - 1); y = 9'(V_RES - 1);
        repeat (10) @(posedge clk);
        #1;
        model_tick(0, 1);
        mover = 1'b0;
        probe(308, 440, "hold_step");
        check("hold_in", {20'd0, color}, 12'h0F0);
        probe(307, 440, "hold_step");
        check("hold_out_l", {20'd0, color}, 12'h000);
        probe(340, 440, "hold_step");
        check("hold_out_r", {20'd0, color}, 12'h000);

        // saturate at the right edge
        for (int f = 0; f < 80; f++) frame(0, 1);
        probe(608, 440, "sat");
        check("sat_in", {20'd0, color}, 12'h0F0);
        probe(607, 440, "sat");
        check("sat_out", {20'd0, color}, 12'h000);
        for (int f = 0; f < 3; f++) frame(1, 1);
        probe(608, 440, "both");
        check("both_in", {20'd0, color}, 12'h0F0);
        probe(607, 440, "both");
        check("both_out", {20'd0, color}, 12'h000);
        obs_probes();

        // steer under a falling obstacle until collision
        for (int f = 0; f < 800 && !m_collide; f++) begin
            tgt = -1; best = -1;
            for (int i = 0; i < N_OBS; i++)
                if (m_act[i] && m_oy[i] < SHIP_Y + SHIP_H && m_oy[i] > best) begin
                    best = m_oy[i]; tgt = m_ox[i];
                end
            ml = 0; mr = 0;
            if (tgt >= 0) begin
                if (m_ship_x < tgt) mr = 1;
                else if (m_ship_x > tgt) ml = 1;
            end
            frame(ml, mr);
        end
        check("chase_collide", {31'd0, collide}, 1);
        probe(m_ship_x, SHIP_Y + 1, "red_ship");
        check("ship_red", {20'd0, color}, 12'hF00);
        frame(0, 1);
        frame(1, 0);
        ship_probes();
        obs_probes();
        frame(1, 1);
        check("restart_collide", {31'd0, collide}, 0);
        check("restart_score", {16'd0, score}, 0);
        probe(SHIP_X0, SHIP_Y, "restart_ship");
        check("restart_ship_green", {20'd0, color}, 12'h0F0);

        // randomized play against the model
        for (int f = 0; f < 2500; f++) begin
            r = $urandom_range(0, 9);
            ml = (r <= 3) || (r == 8);
            mr = (r >= 4 && r <= 8);
            frame(ml, mr);
            ship_probes();
            obs_probes();
            for (int k = 0; k < 2; k++) begin
                px = $urandom_range(0, 700);
                py = $urandom_range(0, 511);
                if (px == H_RES - 1 && py == V_RES - 1) px = 0;
                probe(px, py, "rand");
            end
        end

        // reset mid-scan: outputs clear without a clock edge
        probe(m_ship_x, SHIP_Y, "pre_reset");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_color", {20'd0, color}, 0);
        check("midrst_collide", {31'd0, collide}, 0);
        check("midrst_score", {16'd0, score}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        frame(0, 1);
        ship_probes();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
